// File: rtl/present80_core_if.sv
// Request/response bundle between the register file and the PRESENT-80 engine.
// The master side drives key, plaintext and control; the slave side is the core.
interface present80_core_if;
  logic [79:0] key_i;
  logic [63:0] plain_i;
  logic        start_i;
  logic        clear_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] cipher_o;

  modport master (
    output key_i, plain_i, start_i, clear_i,
    input  busy_o, done_o, cipher_o
  );

  modport slave (
    input  key_i, plain_i, start_i, clear_i,
    output busy_o, done_o, cipher_o
  );
endinterface

// File: rtl/present80_core.sv
// Iterative PRESENT-80 encryption engine: one round per clock, key schedule on the fly.
// Optional sticky completion interrupt (irq_o/irq_clr_i) enabled by defining PRESENT80_IRQ_EN.
module present80_core #(
  parameter int ROUNDS = 31
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  present80_core_if.slave bus
`ifdef PRESENT80_IRQ_EN
  ,
  input  logic irq_clr_i,
  output logic irq_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t        fsm_q;
  logic [63:0] state_q;
  logic [79:0] key_q;
  logic [4:0]  rc_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] cipher_q;

  logic [63:0] add_w;
  logic [63:0] sbox_w;
  logic [63:0] state_d;
  logic [79:0] rot_w;
  logic [79:0] key_d;
  logic        accept_w;
  logic        finish_w;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  assign add_w = state_q ^ key_q[79:16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slayer
      assign sbox_w[gi*4 +: 4] = sbox(add_w[gi*4 +: 4]);
    end
    // Bit permutation: position i goes to 16*i mod 63, bit 63 is a fixed point.
    for (gi = 0; gi < 64; gi++) begin : g_player
      if (gi == 63) begin : g_fixed
        assign state_d[63] = sbox_w[63];
      end else begin : g_move
        assign state_d[(gi*16) % 63] = sbox_w[gi];
      end
    end
  endgenerate

  assign rot_w = {key_q[18:0], key_q[79:19]};
  assign key_d = {sbox(rot_w[79:76]), rot_w[75:20], rot_w[19:15] ^ rc_q, rot_w[14:0]};

  assign accept_w = !bus.clear_i && (fsm_q == IDLE) && bus.start_i;
  assign finish_w = !bus.clear_i && (fsm_q == RUN) && (rc_q == 5'(ROUNDS));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      rc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cipher_q <= '0;
    end else if (bus.clear_i) begin
      // Abort keeps the last completed ciphertext visible.
      fsm_q  <= IDLE;
      rc_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            state_q <= bus.plain_i;
            key_q   <= bus.key_i;
            rc_q    <= 5'd1;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          key_q   <= key_d;
          rc_q    <= rc_q + 5'd1;
          if (rc_q == 5'(ROUNDS)) begin
            cipher_q <= state_d ^ key_d[79:16];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            fsm_q    <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.cipher_o = cipher_q;

`ifdef PRESENT80_IRQ_EN
  logic irq_q;

  // Completion beats any clear request landing on the same edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_q <= 1'b0;
    end else if (finish_w) begin
      irq_q <= 1'b1;
    end else if (irq_clr_i || bus.clear_i || accept_w) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_w;
  assign unused_w = accept_w ^ finish_w;
`endif

endmodule

// File: tb/tb_present80_core.sv
// Directed + randomized bench for present80_core against a round-loop PRESENT-80 model.
// Define PRESENT80_IRQ_EN to also exercise the sticky interrupt.
module tb_present80_core;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] last_cipher = '0;

  present80_core_if ifc ();

`ifdef PRESENT80_IRQ_EN
  logic irq_clr;
  logic irq;
`endif

  present80_core #(.ROUNDS(31)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (ifc.slave)
`ifdef PRESENT80_IRQ_EN
    ,
    .irq_clr_i (irq_clr),
    .irq_o     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end

  // Reference PRESENT-80, written straight from the cipher definition.
  function automatic logic [63:0] model(input logic [79:0] key, input logic [63:0] pt);
    int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    logic [4:0]  r5;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
      k = {k[18:0], k[79:19]};
      k[79:76] = 4'(sb[k[79:76]]);
      r5 = 5'(r);
      k[19:15] = k[19:15] ^ r5;
    end
    return s ^ k[79:16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One block: start pulse, optional ignored restart at cycle 10, optional irq clear on the final edge.
  task automatic run(input logic [79:0] k, input logic [63:0] p, input logic [63:0] exp,
                     input string tag, input bit disturb, input bit clr_end);
    int lat;
    int busy_cnt;
    ifc.key_i   = k;
    ifc.plain_i = p;
    ifc.start_i = 1'b1;
    step();
    ifc.start_i = 1'b0;
    chk({tag, "_cipher_held"}, ifc.cipher_o, last_cipher);
`ifdef PRESENT80_IRQ_EN
    chk({tag, "_irq_cleared_by_start"}, 64'(irq), 64'd0);
`endif
    lat = 0;
    busy_cnt = 0;
    while (ifc.done_o !== 1'b1 && lat < 40) begin
      if (ifc.busy_o === 1'b1) busy_cnt++;
      if (disturb && lat == 9) begin
        ifc.key_i   = {$urandom, $urandom, 16'($urandom)};
        ifc.plain_i = {$urandom, $urandom};
        ifc.start_i = 1'b1;
      end
`ifdef PRESENT80_IRQ_EN
      if (clr_end && lat == 30) irq_clr = 1'b1;
`endif
      step();
      ifc.start_i = 1'b0;
`ifdef PRESENT80_IRQ_EN
      irq_clr = 1'b0;
`endif
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd31);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd31);
    chk({tag, "_cipher"}, ifc.cipher_o, exp);
    chk({tag, "_busy_low_at_done"}, 64'(ifc.busy_o), 64'd0);
`ifdef PRESENT80_IRQ_EN
    chk({tag, "_irq_set"}, 64'(irq), 64'd1);
`endif
    last_cipher = exp;
    step();
    chk({tag, "_done_width"}, 64'(ifc.done_o), 64'd0);
  endtask

  initial begin
    logic [79:0] k;
    logic [63:0] p;
    int done_cnt;

    rst_n       = 1'b0;
    ifc.key_i   = '0;
    ifc.plain_i = '0;
    ifc.start_i = 1'b0;
    ifc.clear_i = 1'b0;
`ifdef PRESENT80_IRQ_EN
    irq_clr = 1'b0;
`endif
    #12;
    chk("reset_busy", 64'(ifc.busy_o), 64'd0);
    chk("reset_done", 64'(ifc.done_o), 64'd0);
    chk("reset_cipher", ifc.cipher_o, 64'd0);
`ifdef PRESENT80_IRQ_EN
    chk("reset_irq", 64'(irq), 64'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    run(80'h0, 64'h0, 64'h5579C1387B228445, "kat_zero", 1'b0, 1'b0);
    run({80{1'b1}}, 64'h0, 64'hE72C46C0F5945049, "kat_key1", 1'b0, 1'b0);
    run(80'h0, {64{1'b1}}, 64'hA112FFC72F68417B, "kat_pt1", 1'b0, 1'b0);
    run({80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, "kat_ones", 1'b0, 1'b0);

    k = {$urandom, $urandom, 16'($urandom)};
    p = {$urandom, $urandom};
    run(k, p, model(k, p), "ignored_restart", 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, 16'($urandom)};
      p = {$urandom, $urandom};
      run(k, p, model(k, p), $sformatf("rand%0d", i), 1'b0, 1'b0);
    end

`ifdef PRESENT80_IRQ_EN
    repeat (3) step();
    chk("irq_sticky", 64'(irq), 64'd1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_clr", 64'(irq), 64'd0);
    k = {$urandom, $urandom, 16'($urandom)};
    p = {$urandom, $urandom};
    run(k, p, model(k, p), "irq_set_wins", 1'b0, 1'b1);
`endif

    // Abort at cycle 15 of a run.
    ifc.key_i   = {$urandom, $urandom, 16'($urandom)};
    ifc.plain_i = {$urandom, $urandom};
    ifc.start_i = 1'b1;
    step();
    ifc.start_i = 1'b0;
    repeat (14) step();
    ifc.clear_i = 1'b1;
    step();
    ifc.clear_i = 1'b0;
    chk("clear_busy", 64'(ifc.busy_o), 64'd0);
    chk("clear_done", 64'(ifc.done_o), 64'd0);
    chk("clear_cipher_kept", ifc.cipher_o, last_cipher);
`ifdef PRESENT80_IRQ_EN
    chk("clear_irq", 64'(irq), 64'd0);
`endif
    ifc.clear_i = 1'b1;
    ifc.start_i = 1'b1;
    step();
    ifc.clear_i = 1'b0;
    ifc.start_i = 1'b0;
    chk("clear_beats_start", 64'(ifc.busy_o), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.done_o === 1'b1) done_cnt++;
      step();
    end
    chk("clear_no_done", 64'(done_cnt), 64'd0);

    k = {$urandom, $urandom, 16'($urandom)};
    p = {$urandom, $urandom};
    run(k, p, model(k, p), "after_clear", 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run.
    ifc.key_i   = {$urandom, $urandom, 16'($urandom)};
    ifc.plain_i = {$urandom, $urandom};
    ifc.start_i = 1'b1;
    step();
    ifc.start_i = 1'b0;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(ifc.busy_o), 64'd0);
    chk("midreset_done", 64'(ifc.done_o), 64'd0);
    chk("midreset_cipher", ifc.cipher_o, 64'd0);
    last_cipher = '0;
    step();
    rst_n = 1'b1;
    step();
    k = {$urandom, $urandom, 16'($urandom)};
    p = {$urandom, $urandom};
    run(k, p, model(k, p), "after_reset", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
